// File: rtl/regfile_mp_sb_if.sv
// Decode/issue and writeback signal bundle for the multi-port register file.
// master = pipeline side driving addresses/writes/alloc; slave = the register file.
interface regfile_mp_sb_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   alloc_en;
    logic [AW-1:0]          alloc_addr;
    logic                   alloc_ok;
    logic                   flush;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        input  rd_data, rd_busy, alloc_ok
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        output rd_data, rd_busy, alloc_ok
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write bypass and per-register pending scoreboard.
// Reads are combinational (zero latency), writes/alloc commit on the rising edge; no backpressure.
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    regfile_mp_sb_if.slave   rf
);
    localparam int AW = $clog2(NREGS);
    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;
    logic [NREGS-1:0] wr_hit;

    logic [AW-1:0]   ra [NUM_RD];
    logic [AW-1:0]   wa [NUM_WR];
    logic [XLEN-1:0] wd [NUM_WR];
    logic [NUM_WR-1:0] we;

    logic [NUM_RD*XLEN-1:0] rd_data_c;
    logic [NUM_RD-1:0]      rd_busy_c;
    logic                   alloc_ok_c;
    logic                   alloc_hit;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign ra[i] = rf.rd_addr[i*AW +: AW];
    end

    // Writes to x0 are dropped up front so every consumer sees the same qualified enable.
    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
        assign wa[j] = rf.wr_addr[j*AW +: AW];
        assign wd[j] = rf.wr_data[j*XLEN +: XLEN];
        assign we[j] = rf.wr_en[j] && !(ZR && (wa[j] == '0));
    end

    always_comb begin
        wr_hit = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (we[j]) wr_hit[wa[j]] = 1'b1;
        end
    end

    always_comb begin : p_read
        logic [XLEN-1:0] d;
        logic            b;
        rd_data_c = '0;
        rd_busy_c = '0;
        d = '0;
        b = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            d = mem[ra[i]];
            if (BP) begin
                // Ascending scan so the highest-index matching port wins, same as the array write.
                for (int j = 0; j < NUM_WR; j++) begin
                    if (we[j] && (wa[j] == ra[i])) d = wd[j];
                end
            end
            b = pend[ra[i]];
            if (BP) b = b && !wr_hit[ra[i]] && !rf.flush;
            if (ZR && (ra[i] == '0)) begin
                d = '0;
                b = 1'b0;
            end
            rd_data_c[i*XLEN +: XLEN] = d;
            rd_busy_c[i]              = b;
        end
    end

    assign alloc_hit = rf.alloc_en && !(ZR && (rf.alloc_addr == '0));

    // Priority low to high: writeback clear, flush, new producer.
    always_comb begin
        pend_nxt = pend & ~wr_hit;
        if (rf.flush) pend_nxt = '0;
        if (alloc_hit) pend_nxt[rf.alloc_addr] = 1'b1;
    end

    always_comb begin
        alloc_ok_c = !pend[rf.alloc_addr] || wr_hit[rf.alloc_addr] || rf.flush;
        if (ZR && (rf.alloc_addr == '0)) alloc_ok_c = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (we[j]) mem[wa[j]] <= wd[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pend <= '0;
        else     pend <= pend_nxt;
    end

    assign rf.rd_data  = rd_data_c;
    assign rf.rd_busy  = rd_busy_c;
    assign rf.alloc_ok = alloc_ok_c;

    always @(posedge clk) begin
        assert (NUM_RD >= 1);
        assert (NUM_WR >= 1);
        assert ((NREGS >= 2) && ((NREGS & (NREGS - 1)) == 0));
        for (int j = 0; j < NUM_WR; j++) begin
            if (rf.wr_en[j] === 1'b1) assert (!$isunknown(wa[j]));
        end
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench: dut_a = zero-reg + bypass, dut_b = no zero-reg, no bypass; both two write ports.
module tb_regfile_mp_sb;
    logic clk;
    logic rst;
    int   passed;
    int   failed;
    int   total;

    regfile_mp_sb_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) ia ();
    regfile_mp_sb_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) ib ();

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1))
        dut_a (.clk(clk), .rst(rst), .rf(ia.slave));
    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0), .BYPASS(0))
        dut_b (.clk(clk), .rst(rst), .rf(ib.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic a_idle();
        ia.wr_en    = 2'b00;
        ia.wr_addr  = '0;
        ia.wr_data  = '0;
        ia.alloc_en = 1'b0;
        ia.flush    = 1'b0;
    endtask

    task automatic b_idle();
        ib.wr_en    = 2'b00;
        ib.wr_addr  = '0;
        ib.wr_data  = '0;
        ib.alloc_en = 1'b0;
        ib.flush    = 1'b0;
    endtask

    initial begin
        passed = 0;
        failed = 0;
        total  = 0;
        a_idle();
        b_idle();
        ia.rd_addr = '0; ia.alloc_addr = '0;
        ib.rd_addr = '0; ib.alloc_addr = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ia.rd_addr = {5'd31, 5'd1}; ia.alloc_addr = 5'd17;
        #1;
        chk("init_rd0",   ia.rd_data[31:0],  32'h0);
        chk("init_rd1",   ia.rd_data[63:32], 32'h0);
        chk("init_busy",  ia.rd_busy,        32'h0);
        chk("init_aok",   ia.alloc_ok,       32'h1);

        // preload x5 and mark it pending, then reset
        ia.wr_en = 2'b01; ia.wr_addr[4:0] = 5'd5; ia.wr_data[31:0] = 32'hDEADBEEF;
        ia.alloc_en = 1'b1; ia.alloc_addr = 5'd5;
        @(negedge clk);
        a_idle();
        ia.rd_addr[4:0] = 5'd5; ia.alloc_addr = 5'd5;
        #1;
        chk("pre_data", ia.rd_data[31:0], 32'hDEADBEEF);
        chk("pre_busy", ia.rd_busy[0],    32'h1);
        chk("pre_aok",  ia.alloc_ok,      32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ia.rd_addr = {5'd0, 5'd5};
        #1;
        chk("rst_data", ia.rd_data[31:0], 32'h0);
        chk("rst_busy", ia.rd_busy,       32'h0);
        chk("rst_aok",  ia.alloc_ok,      32'h1);

        // same-address dual write: port 1 wins
        @(negedge clk);
        ia.wr_en = 2'b11; ia.wr_addr = {5'd7, 5'd7}; ia.wr_data = {32'h22, 32'h11};
        ia.rd_addr = {5'd7, 5'd7};
        #1;
        chk("byp_rd0", ia.rd_data[31:0],  32'h22);
        chk("byp_rd1", ia.rd_data[63:32], 32'h22);
        @(negedge clk);
        a_idle();
        ia.rd_addr[4:0] = 5'd7;
        #1;
        chk("byp_stored", ia.rd_data[31:0], 32'h22);
        @(negedge clk);
        ia.wr_en = 2'b11; ia.wr_addr = {5'd12, 5'd8}; ia.wr_data = {32'h44, 32'h33};
        ia.rd_addr = {5'd12, 5'd8};
        #1;
        chk("byp2_rd0", ia.rd_data[31:0],  32'h33);
        chk("byp2_rd1", ia.rd_data[63:32], 32'h44);

        // zero register: write and alloc x0 on both DUTs
        @(negedge clk);
        a_idle();
        ia.wr_en = 2'b01; ia.wr_addr[4:0] = 5'd0; ia.wr_data[31:0] = 32'hFFFFFFFF;
        ia.alloc_en = 1'b1; ia.alloc_addr = 5'd0; ia.rd_addr = {5'd12, 5'd0};
        ib.wr_en = 2'b01; ib.wr_addr[4:0] = 5'd0; ib.wr_data[31:0] = 32'hFFFFFFFF;
        ib.alloc_en = 1'b1; ib.alloc_addr = 5'd0;
        #1;
        chk("z_data",    ia.rd_data[31:0],  32'h0);
        chk("z_busy",    ia.rd_busy[0],     32'h0);
        chk("z_aok",     ia.alloc_ok,       32'h1);
        chk("z_x12",     ia.rd_data[63:32], 32'h44);
        @(negedge clk);
        a_idle(); b_idle();
        ia.rd_addr[4:0] = 5'd0; ib.rd_addr[4:0] = 5'd0;
        #1;
        chk("z_next_data", ia.rd_data[31:0], 32'h0);
        chk("z_next_busy", ia.rd_busy[0],    32'h0);
        chk("nz_data",     ib.rd_data[31:0], 32'hFFFFFFFF);
        chk("nz_busy",     ib.rd_busy[0],    32'h1);

        // scoreboard on x3
        @(negedge clk);
        ia.alloc_en = 1'b1; ia.alloc_addr = 5'd3;
        ib.alloc_en = 1'b1; ib.alloc_addr = 5'd3;
        @(negedge clk);
        a_idle(); b_idle();
        ia.rd_addr[4:0] = 5'd3; ia.alloc_addr = 5'd3;
        #1;
        chk("sb_busy", ia.rd_busy[0], 32'h1);
        chk("sb_aok",  ia.alloc_ok,   32'h0);
        ia.wr_en = 2'b01; ia.wr_addr[4:0] = 5'd3; ia.wr_data[31:0] = 32'h5;
        ib.wr_en = 2'b01; ib.wr_addr[4:0] = 5'd3; ib.wr_data[31:0] = 32'h5;
        ib.rd_addr[4:0] = 5'd3; ib.alloc_addr = 5'd3;
        #1;
        chk("sb_wb_busy",  ia.rd_busy[0],    32'h0);
        chk("sb_wb_data",  ia.rd_data[31:0], 32'h5);
        chk("sb_wb_aok",   ia.alloc_ok,      32'h1);
        chk("nb_wb_busy",  ib.rd_busy[0],    32'h1);
        chk("nb_wb_data",  ib.rd_data[31:0], 32'h0);
        chk("nb_wb_aok",   ib.alloc_ok,      32'h1);
        @(negedge clk);
        a_idle(); b_idle();
        #1;
        chk("sb_after_busy", ia.rd_busy[0],    32'h0);
        chk("sb_after_data", ia.rd_data[31:0], 32'h5);
        chk("nb_after_busy", ib.rd_busy[0],    32'h0);
        chk("nb_after_data", ib.rd_data[31:0], 32'h5);

        // alloc and writeback to x9 in the same cycle
        @(negedge clk);
        ia.alloc_en = 1'b1; ia.alloc_addr = 5'd9;
        ia.wr_en = 2'b01; ia.wr_addr[4:0] = 5'd9; ia.wr_data[31:0] = 32'hAB;
        @(negedge clk);
        a_idle();
        ia.rd_addr[4:0] = 5'd9;
        #1;
        chk("col_busy", ia.rd_busy[0],    32'h1);
        chk("col_data", ia.rd_data[31:0], 32'hAB);
        @(negedge clk);
        ia.alloc_en = 1'b1; ia.alloc_addr = 5'd10;
        @(negedge clk);
        a_idle();
        ia.alloc_en = 1'b1; ia.alloc_addr = 5'd9; ia.flush = 1'b1;
        ia.wr_en = 2'b01; ia.wr_addr[4:0] = 5'd11; ia.wr_data[31:0] = 32'h77;
        ia.rd_addr = {5'd10, 5'd9};
        #1;
        chk("fl_busy", ia.rd_busy,  32'h0);
        chk("fl_aok",  ia.alloc_ok, 32'h1);
        @(negedge clk);
        a_idle();
        ia.alloc_addr = 5'd10;
        #1;
        chk("fl_after_busy", ia.rd_busy,  32'h1);
        chk("fl_after_aok",  ia.alloc_ok, 32'h1);
        @(negedge clk);
        ia.rd_addr[4:0] = 5'd11;
        #1;
        chk("fl_write", ia.rd_data[31:0], 32'h77);

        // reset overrides a pending write, clear and alloc
        @(negedge clk);
        ia.alloc_en = 1'b1; ia.alloc_addr = 5'd4;
        @(negedge clk);
        rst = 1'b1;
        ia.alloc_en = 1'b1; ia.alloc_addr = 5'd6;
        ia.wr_en = 2'b01; ia.wr_addr[4:0] = 5'd4; ia.wr_data[31:0] = 32'h99;
        @(negedge clk);
        rst = 1'b0;
        a_idle();
        ia.rd_addr = {5'd9, 5'd4}; ia.alloc_addr = 5'd6;
        #1;
        chk("rmid_x4",   ia.rd_data[31:0],  32'h0);
        chk("rmid_x9",   ia.rd_data[63:32], 32'h0);
        chk("rmid_busy", ia.rd_busy,        32'h0);
        chk("rmid_aok6", ia.alloc_ok,       32'h1);
        ia.rd_addr = {5'd6, 5'd4}; ia.alloc_addr = 5'd4;
        #1;
        chk("rmid_busy6", ia.rd_busy,  32'h0);
        chk("rmid_aok4",  ia.alloc_ok, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file for the pipelined core, generalising the single-write, two-read register file. It adds configurable read and write port counts, a synchronous clear on reset, write-to-read bypass across all write ports, and a per-register pending scoreboard. The scoreboard lets multi-cycle units (MUL/DIV, loads) mark a destination busy at issue and clear it at writeback. It sits between decode/issue (read ports, alloc) and the writeback stage (write ports).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2); AW = $clog2(NREGS)
NUM_RD, 2, number of read ports (>=1)
NUM_WR, 1, number of write ports (>=1)
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending
BYPASS, 1, 1 = same-cycle write data and clears are visible on read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
rd_addr  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NUM_RD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_busy  out  NUM_RD  port i register pending (operand not yet produced)
wr_en  in  NUM_WR  write enables
wr_addr  in  NUM_WR*AW  write addresses
wr_data  in  NUM_WR*XLEN  write data
alloc_en  in  1  mark alloc_addr pending (issue of a producer)
alloc_addr  in  AW  register to mark pending
alloc_ok  out  1  alloc_addr not pending after this cycle's clears (WAW check)
flush  in  1  clear all pending bits (pipeline flush); writes still commit

Behaviour:
- Storage: NREGS x XLEN array plus NREGS-bit pending vector.
- Reset: on a rising edge with rst=1, all registers are set to 0 and all pending bits to 0. rst overrides wr_en, alloc_en and flush in that cycle. After reset, rd_data=0, rd_busy=0 and alloc_ok=1 for every address.
- Reads: combinational, zero latency.
  - Per port: if ZERO_REG and addr==0, data=0.
  - Else if BYPASS and any wr_en[j] with wr_addr[j]==addr (and addr!=0 when ZERO_REG), data = wr_data of the highest-index matching j.
  - Else data = array[addr].
- Writes: at the rising edge, array[wr_addr[j]] <= wr_data[j] for each enabled j.
  - Address 0 is skipped when ZERO_REG.
  - Two or more ports writing the same address in one cycle: the highest index wins. The stored value equals the bypassed value.
- Pending vector: next-state per register r, evaluated in this priority order:
  1. rst -> 0
  2. alloc_en && alloc_addr==r -> 1 (a new producer wins over a same-cycle clear, and over flush)
  3. flush -> 0
  4. any wr_en[j] with wr_addr[j]==r -> 0
  5. otherwise hold
- ZERO_REG=1: alloc to 0 is ignored, and pending[0] stays 0.
- rd_busy[i]:
  - BYPASS=1: pending[rd_addr[i]] && no same-cycle write to rd_addr[i] && !flush.
  - BYPASS=0: pending[rd_addr[i]] unmasked.
  - Forced 0 for address 0 when ZERO_REG.
- alloc_ok: !pending[alloc_addr] || (a same-cycle write clears it) || flush. It is 1 for address 0 when ZERO_REG. It is informational only; alloc_en always sets pending regardless of alloc_ok.
- Writes to non-pending registers are legal and do not affect pending bits.
- Assertions (sim only):
  - no X on wr_addr when wr_en=1;
  - NUM_RD >= 1;
  - NUM_WR >= 1;
  - NREGS is a power of two.

Test Plan:
- Reset: preload x5=0xDEADBEEF, then assert rst for 1 cycle -> every rd_data=0, every rd_busy=0, alloc_ok=1.
- Bypass: NUM_WR=2, same cycle wr0(x7,0x11), wr1(x7,0x22), rd_addr0=7 -> rd_data0=0x22 that cycle; next cycle x7 reads 0x22.
- Zero register: write x0=0xFFFFFFFF, alloc x0 -> rd x0 returns 0, rd_busy=0. With ZERO_REG=0 the same stimulus -> x0 reads 0xFFFFFFFF.
- Scoreboard: alloc x3 -> next cycle rd_busy=1 and alloc_ok(x3)=0. Write x3=0x5 -> rd_busy=0 combinationally that cycle (BYPASS=1), data=0x5; pending cleared next cycle.
- Alloc vs clear collision: same cycle alloc x9 and write x9 -> next cycle pending[9]=1 and x9 holds the written value. Alloc + flush same cycle -> only x9 remains pending.
- Reset mid-operation: x4 pending with wr_en to x4 and alloc x6 while rst=1 -> x4=0, all pending 0, x6 not pending.
